// File: rtl/tx_os_scheduler.sv
// TX datapath arbiter between the LPIF data FIFO and the ordered-set generator.
// Serves LTSSM ordered-set requests and owes periodic SKP sets while the link is up.
module tx_os_scheduler #(
  parameter int unsigned SKP_INTERVAL_8B10B = 1180,
  parameter int unsigned SKP_INTERVAL_128B  = 5920,
  parameter logic [2:0]  SKP_OS_TYPE        = 3'd4,
  parameter logic [1:0]  MAX_PENDING        = 2'd3
) (
  input  logic       pclk,
  input  logic       reset_n,
  input  logic [2:0] gen,
  input  logic       link_up,
  input  logic       pkt_start,
  input  logic       pkt_end,
  input  logic       ltssm_os_req,
  input  logic [2:0] ltssm_os_type,
  input  logic       os_busy,
  input  logic       os_finish,
  output logic       os_start,
  output logic [2:0] os_type,
  output logic       mux_sel,
  output logic       hold,
  output logic       ltssm_os_ack,
  output logic [1:0] skp_pending,
  output logic       skp_overflow
);

  typedef enum logic [1:0] {S_LINKDOWN, S_DATA, S_GRANT, S_WAIT} state_e;

  state_e      state_q, state_d;
  logic        pkt_open_q, pkt_open_d;
  logic [12:0] timer_q, timer_d;
  logic [1:0]  skp_pending_q, skp_pending_d;
  logic        skp_overflow_q, skp_overflow_d;
  logic [2:0]  gen_q;
  logic        os_start_q, ltssm_os_ack_q, mux_sel_q, hold_q;
  logic [2:0]  os_type_q, os_type_d;

  logic        grant_ltssm_s, grant_skp_s;
  logic        boundary_s, skp_owed_s, expire_s, restart_s, credit_s;
  logic [12:0] interval_last_s;

  assign boundary_s      = ~pkt_open_q & ~pkt_start;
  assign skp_owed_s      = (skp_pending_q != 2'd0);
  assign interval_last_s = (gen < 3'd3) ? 13'(SKP_INTERVAL_8B10B - 32'd1)
                                        : 13'(SKP_INTERVAL_128B - 32'd1);
  assign expire_s        = (timer_q == interval_last_s);
  assign restart_s       = ~link_up | (gen != gen_q);
  // A credit is only earned when the owed counter has room; at the cap the timer parks.
  assign credit_s        = expire_s & (skp_pending_q != MAX_PENDING);
  assign pkt_open_d      = (pkt_open_q | pkt_start) & ~pkt_end;

  // Next-state and grant decision
  always_comb begin
    state_d       = state_q;
    grant_ltssm_s = 1'b0;
    grant_skp_s   = 1'b0;
    case (state_q)
      S_LINKDOWN: begin
        if (ltssm_os_req && !os_busy) begin
          grant_ltssm_s = 1'b1;
        end else if (link_up && !ltssm_os_req) begin
          state_d = S_DATA;
        end else begin
          state_d = S_LINKDOWN;
        end
      end
      S_DATA: begin
        if (!link_up) begin
          state_d = S_LINKDOWN;
        end else if ((ltssm_os_req || skp_owed_s) && boundary_s && !os_busy) begin
          grant_ltssm_s = ltssm_os_req;
          grant_skp_s   = ~ltssm_os_req;
        end else begin
          state_d = S_DATA;
        end
      end
      S_GRANT: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!os_finish) begin
          state_d = S_WAIT;
        end else if (ltssm_os_req && !os_busy) begin
          grant_ltssm_s = 1'b1;
        end else if (link_up && skp_owed_s && !os_busy) begin
          grant_skp_s = 1'b1;
        end else if (link_up) begin
          state_d = S_DATA;
        end else begin
          state_d = S_LINKDOWN;
        end
      end
      default: begin
        state_d = S_LINKDOWN;
      end
    endcase
    if (grant_ltssm_s || grant_skp_s) begin
      state_d = S_GRANT;
    end else begin
      state_d = state_d;
    end
  end

  // OS type latched on grant, held until the next grant
  always_comb begin
    os_type_d = os_type_q;
    if (grant_ltssm_s) begin
      os_type_d = ltssm_os_type;
    end else if (grant_skp_s) begin
      os_type_d = SKP_OS_TYPE;
    end else begin
      os_type_d = os_type_q;
    end
  end

  // SKP interval timer and owed-SKP bookkeeping
  always_comb begin
    timer_d        = timer_q;
    skp_pending_d  = skp_pending_q;
    skp_overflow_d = skp_overflow_q;
    if (restart_s) begin
      timer_d       = 13'd0;
      skp_pending_d = 2'd0;
    end else begin
      if (!expire_s) begin
        timer_d = timer_q + 13'd1;
      end else if (credit_s) begin
        timer_d = 13'd0;
      end else begin
        skp_overflow_d = 1'b1;
      end
      if (credit_s && !grant_skp_s) begin
        skp_pending_d = skp_pending_q + 2'd1;
      end else if (grant_skp_s && !credit_s) begin
        skp_pending_d = skp_pending_q - 2'd1;
      end else begin
        skp_pending_d = skp_pending_q;
      end
    end
  end

  // State, bookkeeping and registered outputs
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_LINKDOWN;
      pkt_open_q     <= 1'b0;
      timer_q        <= 13'd0;
      skp_pending_q  <= 2'd0;
      skp_overflow_q <= 1'b0;
      gen_q          <= 3'd0;
      os_start_q     <= 1'b0;
      os_type_q      <= 3'd0;
      ltssm_os_ack_q <= 1'b0;
      mux_sel_q      <= 1'b1;
      hold_q         <= 1'b1;
    end else begin
      state_q        <= state_d;
      pkt_open_q     <= pkt_open_d;
      timer_q        <= timer_d;
      skp_pending_q  <= skp_pending_d;
      skp_overflow_q <= skp_overflow_d;
      gen_q          <= gen;
      os_start_q     <= grant_ltssm_s | grant_skp_s;
      os_type_q      <= os_type_d;
      ltssm_os_ack_q <= grant_ltssm_s;
      mux_sel_q      <= (state_d != S_DATA);
      hold_q         <= (state_d != S_DATA);
    end
  end

  assign os_start     = os_start_q;
  assign os_type      = os_type_q;
  assign mux_sel      = mux_sel_q;
  assign hold         = hold_q;
  assign ltssm_os_ack = ltssm_os_ack_q;
  assign skp_pending  = skp_pending_q;
  assign skp_overflow = skp_overflow_q;

endmodule

// File: tb/tb_tx_os_scheduler.sv
// Bench for tx_os_scheduler: directed scenarios plus random traffic, every cycle
// compared against a cycle-level reference of the scheduling rules.
module tb_tx_os_scheduler;

  logic       pclk = 1'b0;
  logic       reset_n;
  logic [2:0] gen;
  logic       link_up, pkt_start, pkt_end, ltssm_os_req, os_busy, os_finish;
  logic [2:0] ltssm_os_type;
  logic       os_start, mux_sel, hold, ltssm_os_ack, skp_overflow;
  logic [2:0] os_type;
  logic [1:0] skp_pending;

  int total = 0;
  int bad   = 0;

  localparam int PH_DOWN = 0, PH_TRAFFIC = 1, PH_START = 2, PH_RUN = 3;
  localparam logic [9:0] RST_VEC = {1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0};

  int         m_phase;
  bit         m_pkt_open, m_ovf, exp_start, exp_ack;
  int         m_timer, m_skp;
  logic [2:0] m_type, m_gen_prev;

  int busy_left = 0;
  bit hold_fin  = 1'b0;
  bit rand_busy = 1'b0;

  tx_os_scheduler dut (
    .pclk(pclk), .reset_n(reset_n), .gen(gen), .link_up(link_up),
    .pkt_start(pkt_start), .pkt_end(pkt_end), .ltssm_os_req(ltssm_os_req),
    .ltssm_os_type(ltssm_os_type), .os_busy(os_busy), .os_finish(os_finish),
    .os_start(os_start), .os_type(os_type), .mux_sel(mux_sel), .hold(hold),
    .ltssm_os_ack(ltssm_os_ack), .skp_pending(skp_pending), .skp_overflow(skp_overflow)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] obs_vec();
    return {os_start, os_type, mux_sel, hold, ltssm_os_ack, skp_pending, skp_overflow};
  endfunction

  function automatic logic [9:0] exp_vec();
    bit on_os = (m_phase != PH_TRAFFIC);
    return {exp_start, m_type, on_os, on_os, exp_ack, 2'(m_skp), m_ovf};
  endfunction

  function automatic void m_reset();
    m_phase = PH_DOWN; m_pkt_open = 1'b0; m_timer = 0; m_skp = 0; m_ovf = 1'b0;
    m_type = 3'd0; m_gen_prev = gen; exp_start = 1'b0; exp_ack = 1'b0;
  endfunction

  // One clock of the scheduling rules, applied to the inputs currently driven.
  function automatic void model_step();
    bit boundary = !m_pkt_open && !pkt_start;
    bit give_l = 1'b0;
    bit give_s = 1'b0;
    int next_phase = m_phase;
    int interval = (gen < 3'd3) ? 1180 : 5920;
    int credit = 0;
    case (m_phase)
      PH_DOWN:
        if (ltssm_os_req && !os_busy) give_l = 1'b1;
        else if (link_up && !ltssm_os_req) next_phase = PH_TRAFFIC;
      PH_TRAFFIC:
        if (!link_up) next_phase = PH_DOWN;
        else if ((ltssm_os_req || m_skp > 0) && boundary && !os_busy) begin
          if (ltssm_os_req) give_l = 1'b1; else give_s = 1'b1;
        end
      PH_START: next_phase = PH_RUN;
      default:
        if (os_finish) begin
          if (ltssm_os_req && !os_busy) give_l = 1'b1;
          else if (link_up && m_skp > 0 && !os_busy) give_s = 1'b1;
          else next_phase = link_up ? PH_TRAFFIC : PH_DOWN;
        end
    endcase
    if (give_l || give_s) next_phase = PH_START;
    if (give_l) m_type = ltssm_os_type;
    if (give_s) m_type = 3'd4;
    if (!link_up || gen != m_gen_prev) begin
      m_timer = 0; m_skp = 0;
    end else begin
      if (m_timer == interval - 1) begin
        if (m_skp == 3) m_ovf = 1'b1;
        else begin m_timer = 0; credit = 1; end
      end else m_timer++;
      m_skp = m_skp + credit - (give_s ? 1 : 0);
    end
    m_gen_prev = gen;
    m_pkt_open = (m_pkt_open || pkt_start) && !pkt_end;
    m_phase = next_phase;
    exp_start = give_l || give_s;
    exp_ack = give_l;
  endfunction

  // Advance one clock, compare all outputs, then play the LTSSM and OS generator.
  task automatic tick();
    model_step();
    @(posedge pclk);
    #1;
    check("outputs", 16'(obs_vec()), 16'(exp_vec()));
    os_finish = 1'b0;
    if (exp_ack) ltssm_os_req = 1'b0;
    if (os_start) begin
      os_busy = 1'b1;
      busy_left = $urandom_range(4, 1);
    end else if (busy_left > 0) begin
      if (!hold_fin) begin
        busy_left--;
        if (busy_left == 0) begin os_busy = 1'b0; os_finish = 1'b1; end
      end
    end else if (rand_busy) os_busy = ($urandom_range(7, 0) == 0);
    else os_busy = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic link_restart(input logic [2:0] g);
    link_up = 1'b0; pkt_start = 1'b0; pkt_end = 1'b0; gen = g;
    run(3);
    link_up = 1'b1;
  endtask

  initial begin
    int first, n_start;
    bit mux_dropped;
    logic [2:0] rtype;

    // Reset with a pending LTSSM request while the link is down
    reset_n = 1'b0; gen = 3'd1; link_up = 1'b0; pkt_start = 1'b0; pkt_end = 1'b0;
    ltssm_os_req = 1'b1; ltssm_os_type = 3'd1; os_busy = 1'b0; os_finish = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    check("reset_values", 16'(obs_vec()), 16'(RST_VEC));
    m_reset();
    reset_n = 1'b1;
    tick();
    check("ltssm_grant_linkdown", 16'({os_start, ltssm_os_ack, os_type, mux_sel}),
          16'({1'b1, 1'b1, 3'd1, 1'b1}));
    run(8);
    check("linkdown_hold", 16'(hold), 16'(1'b1));

    // First SKP after link-up on an idle LPIF
    link_restart(3'd1);
    first = 0;
    for (int k = 1; k <= 1300 && first == 0; k++) begin
      tick();
      if (os_start) first = k;
    end
    check("skp_first_cycle", 16'(first), 16'd1181);
    check("skp_first_type", 16'(os_type), 16'd4);
    run(20);

    // SKP owed during an open packet waits for the packet boundary
    link_restart(3'd1);
    first = 0;
    for (int k = 1; k <= 1300 && first == 0; k++) begin
      pkt_start = (k == 1175);
      pkt_end   = (k == 1190);
      tick();
      if (os_start) first = k;
    end
    pkt_start = 1'b0; pkt_end = 1'b0;
    check("skp_after_packet", 16'(first), 16'd1191);
    run(20);

    // LTSSM request and owed SKP together: LTSSM first, SKP back-to-back
    link_restart(3'd1);
    rtype = 3'($urandom_range(7, 0));
    n_start = 0; mux_dropped = 1'b0;
    for (int k = 1; k <= 1500 && n_start < 2; k++) begin
      pkt_start = (k == 1170);
      pkt_end   = (k == 1185);
      if (k == 1175) begin ltssm_os_req = 1'b1; ltssm_os_type = rtype; end
      tick();
      if (n_start >= 1 && mux_sel == 1'b0) mux_dropped = 1'b1;
      if (os_start) begin
        n_start++;
        if (n_start == 1)
          check("b2b_ltssm_first", 16'({ltssm_os_ack, os_type, skp_pending}), 16'({1'b1, rtype, 2'd1}));
        else
          check("b2b_skp_second", 16'({ltssm_os_ack, os_type, skp_pending}), 16'({1'b0, 3'd4, 2'd0}));
      end
    end
    pkt_start = 1'b0; pkt_end = 1'b0;
    check("b2b_grants", 16'(n_start), 16'd2);
    check("b2b_no_data_gap", 16'(mux_dropped), 16'd0);
    run(20);

    // Withheld os_finish: owed SKPs saturate, overflow is sticky, gen change restarts timer
    link_restart(3'd1);
    hold_fin = 1'b1;
    run(1181 + 4 * 1180 + 10);
    check("skp_saturated", 16'(skp_pending), 16'd3);
    check("skp_overflow_set", 16'(skp_overflow), 16'd1);
    hold_fin = 1'b0;
    run(60);
    check("skp_drained", 16'(skp_pending), 16'd0);
    check("skp_overflow_sticky", 16'(skp_overflow), 16'd1);
    gen = 3'd3;
    first = 0;
    for (int k = 1; k <= 6100 && first == 0; k++) begin
      tick();
      if (os_start) first = k;
    end
    check("gen3_skp_cycle", 16'(first), 16'd5922);
    run(20);

    // Random traffic, link flaps, generation changes and LTSSM requests
    link_restart(3'($urandom_range(3, 1)));
    rand_busy = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(299, 0) == 0) link_up = ~link_up;
      if ($urandom_range(999, 0) == 0) gen = 3'($urandom_range(3, 1));
      pkt_start = 1'b0; pkt_end = 1'b0;
      if (m_pkt_open) pkt_end = ($urandom_range(9, 0) == 0);
      else if (m_phase == PH_TRAFFIC) begin
        pkt_start = ($urandom_range(5, 0) == 0);
        pkt_end   = pkt_start && ($urandom_range(3, 0) == 0);
      end
      if (!ltssm_os_req && $urandom_range(59, 0) == 0) begin
        ltssm_os_req = 1'b1;
        ltssm_os_type = 3'($urandom_range(7, 0));
      end
      tick();
    end
    pkt_start = 1'b0; pkt_end = m_pkt_open;
    rand_busy = 1'b0;
    tick();
    pkt_end = 1'b0;
    run(30);

    // Asynchronous reset while waiting on the OS generator
    link_restart(3'd1);
    hold_fin = 1'b1;
    ltssm_os_req = 1'b1; ltssm_os_type = 3'd2;
    for (int k = 0; k < 10 && m_phase != PH_RUN; k++) tick();
    check("in_wait_before_reset", 16'({mux_sel, hold}), 16'({1'b1, 1'b1}));
    #3;
    reset_n = 1'b0;
    #1;
    check("async_reset_values", 16'(obs_vec()), 16'(RST_VEC));
    link_up = 1'b0; ltssm_os_req = 1'b0; os_busy = 1'b0; os_finish = 1'b0;
    busy_left = 0; hold_fin = 1'b0;
    m_reset();
    #2;
    reset_n = 1'b1;
    run(5);
    link_up = 1'b1;
    run(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
